// File: rtl/matmul_job_scheduler.sv
// Job sequencer for the matrix-multiply engine: walks every (row of A, column of B) pair,
// tracks results through the adder-tree latency, writes them row-major, and arbitrates host access.
module matmul_job_scheduler #(
    parameter int ROW_AW   = 6,
    parameter int COL_AW   = 6,
    parameter int OUT_AW   = 12,
    parameter int PIPE_LAT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ROW_AW-1:0] cfg_rows_m1,
    input  logic [COL_AW-1:0] cfg_cols_m1,
    input  logic              host_req,
    output logic              host_gnt,
    output logic              en_a,
    output logic              en_b,
    output logic              we_a,
    output logic              we_b,
    output logic [ROW_AW-1:0] addr_a,
    output logic [COL_AW-1:0] addr_b,
    output logic              en_out,
    output logic              we_out,
    output logic [OUT_AW-1:0] addr_out,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [ROW_AW-1:0]   rows_m1;
    logic [COL_AW-1:0]   cols_m1;
    logic [ROW_AW-1:0]   row_idx;
    logic [COL_AW-1:0]   col_idx;
    logic [OUT_AW-1:0]   wr_cnt;
    logic [PIPE_LAT-1:0] valid_pipe;
    logic                host_gnt_q;
    logic                aborted_q;

    logic start_ok;
    logic abort_ok;
    logic issuing;
    logic last_issue;
    logic pipe_drained;
    logic write_en;

    assign start_ok   = (state == IDLE) && start && !host_gnt_q;
    assign abort_ok   = (state != IDLE) && abort;
    assign issuing    = (state == ISSUE);
    assign last_issue = issuing && (row_idx == rows_m1) && (col_idx == cols_m1);
    assign write_en   = valid_pipe[PIPE_LAT-1];

    // Looks one shift ahead so FIN follows the last write directly (PIPE_LAT >= 2).
    assign pipe_drained = (valid_pipe[PIPE_LAT-2:0] == '0);

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (abort_ok) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok)     state_nxt = ISSUE;
                ISSUE:   if (last_issue)   state_nxt = DRAIN;
                DRAIN:   if (pipe_drained) state_nxt = FIN;
                FIN:                       state_nxt = IDLE;
                default:                   state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: all state updates use <= so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rows_m1    <= '0;
            cols_m1    <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
            wr_cnt     <= '0;
            valid_pipe <= '0;
            host_gnt_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            aborted_q  <= abort_ok;
            host_gnt_q <= (state == IDLE) && host_req && !start_ok;

            // Clearing the delay line is what stops in-flight results from being written after abort.
            if (abort_ok) begin
                valid_pipe <= '0;
            end else begin
                valid_pipe <= {valid_pipe[PIPE_LAT-2:0], issuing};
            end

            if (start_ok) begin
                rows_m1 <= cfg_rows_m1;
                cols_m1 <= cfg_cols_m1;
                row_idx <= '0;
                col_idx <= '0;
                wr_cnt  <= '0;
            end else begin
                if (issuing) begin
                    if (col_idx == cols_m1) begin
                        col_idx <= '0;
                        row_idx <= row_idx + 1'b1;
                    end else begin
                        col_idx <= col_idx + 1'b1;
                    end
                end
                if (write_en) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    assign en_a     = issuing;
    assign en_b     = issuing;
    assign we_a     = 1'b0;
    assign we_b     = 1'b0;
    assign addr_a   = issuing ? row_idx : '0;
    assign addr_b   = issuing ? col_idx : '0;
    assign en_out   = write_en;
    assign we_out   = write_en;
    assign addr_out = write_en ? wr_cnt : '0;
    assign busy     = (state != IDLE);
    // A same-cycle abort in FIN turns the completion into an abort.
    assign done     = (state == FIN) && !abort;
    assign aborted  = aborted_q;
    assign host_gnt = host_gnt_q;

endmodule
